commit_trace_unit: RTL and testbench
====================================

Name: commit_trace_unit

Overview:
Synthesizable retire-trace recorder for the pipelined WISC CPU. It replaces the behavioural trace logic that the testbench keeps today. The WB stage presents one retire event per cycle. The block classifies and numbers each event, filters it by mode, and buffers it in a FIFO that is drained through a valid/ready port (to a debug UART or a bench monitor). It also keeps cycle and instruction counters, handles halt-drain, and runs a cycle watchdog.

Parameters:
DATA_W, 16, width of PC, instruction, data and address fields
DEPTH, 16, FIFO entries; power of two, minimum 2
CNT_W, 32, width of the cycle, instruction and drop counters and the inum field
MAX_CYCLES, 100000, watchdog limit in cycles; 0 disables the watchdog

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous reset, active-high
mode  in  3  filter mask: bit0 REG entries, bit1 STORE entries, bit2 OTHER entries; HALT entries are always kept
ret_valid  in  1  a retire event is present this cycle
ret_pc  in  DATA_W  PC of the retiring instruction
ret_inst  in  DATA_W  instruction word
ret_regwrite  in  1  register file write
ret_wreg  in  4  destination register
ret_wdata  in  DATA_W  data written to the register
ret_memread  in  1  instruction is a load
ret_memwrite  in  1  instruction is a store
ret_addr  in  DATA_W  memory address
ret_mdata  in  DATA_W  store data
ret_halt  in  1  instruction is HLT
out_valid  out  1  FIFO head is valid
out_ready  in  1  consumer accepts the head
out_kind  out  2  entry kind: 0 OTHER, 1 REG, 2 STORE, 3 HALT
out_load  out  1  REG entry came from a load (out_addr is meaningful)
out_inum  out  CNT_W  instruction number, starting at 0
out_pc  out  DATA_W  PC of the entry
out_reg  out  4  destination register (REG entries only, else 0)
out_val  out  DATA_W  wdata for REG, mdata for STORE, else 0
out_addr  out  DATA_W  address for loads and STORE, else 0
cycle_count  out  CNT_W  cycles counted since reset
inst_count  out  CNT_W  accepted retire events
drop_count  out  CNT_W  entries lost to overflow
overflow  out  1  sticky; set on the first drop
timeout  out  1  sticky; watchdog expired
done  out  1  stopped and FIFO empty

Behaviour:
- Reset: FIFO empty, all counters 0, overflow, timeout and done 0, state RUN. All out_* fields read 0 while out_valid=0.
- Classification of each accepted event, in priority order: regwrite -> REG (out_load = memread); else halt -> HALT; else memwrite -> STORE; else OTHER.
- In RUN, ret_valid=1 accepts the event.
  - inum = inst_count. inst_count increments whether or not the entry passes the filter.
  - The entry is pushed only if its kind is enabled by mode (HALT always is).
- Push to FIFO: the entry is written on the same edge the event is accepted. out_valid rises the next cycle (1-cycle latency).
- Pop: a pop occurs when out_valid and out_ready. out_* fields must hold stable while out_valid=1 and out_ready=0.
- Full FIFO with a push and no pop: the non-HALT entry is dropped; drop_count increments and overflow is set.
- Full FIFO with a simultaneous push and pop: both occur and nothing is dropped.
- HALT with the FIFO full and no pop: the HALT entry is held in a 1-entry pending register and the state becomes HALT_PEND. It is pushed on the first cycle with space, then the state becomes DRAIN.
- HALT with space available: it is pushed immediately and the state becomes DRAIN.
- cycle_count increments every cycle in RUN and HALT_PEND, and freezes in DRAIN and DONE.
- Watchdog: when MAX_CYCLES != 0 and cycle_count reaches MAX_CYCLES - 1 in RUN, timeout is set on that edge and the state becomes DRAIN. No HALT entry is generated.
- In DRAIN, HALT_PEND and DONE, ret_valid is ignored; inst_count does not change and nothing is pushed.
- DRAIN -> DONE when the FIFO is empty. done=1 in DONE. DONE is left only by rst.
- rst asserted mid-operation clears everything in the same edge, including FIFO contents, the pending HALT and the sticky flags.
- Counters saturate at all-ones; they never wrap.

Test Plan:
- mode=7, out_ready=1; retire ADD (regwrite, wreg=3, wdata=0x0005, pc=0x0000) -> one cycle later: out_valid=1, kind=1, inum=0, reg=3, val=0x0005.
- Load at pc=0x0002 (regwrite+memread, addr=0x0010, wdata=0x1234) -> kind=1, load=1, addr=0x0010. Store at 0x0004 (addr=0x0020, mdata=0xBEEF) -> kind=2, val=0xBEEF, inum=2.
- mode=1; retire branch, store, then ADD -> only the REG entry appears, with inum=2; inst_count=3.
- DEPTH=4, out_ready=0, 6 REG retires -> 4 entries held; drop_count=2; overflow=1. Then out_ready=1 -> inums 0..3 in order.
- FIFO full, out_ready=0, HALT retires, then 2 more retires -> HALT is pending and the later retires are ignored. After out_ready=1, HALT pops last; done=1 one cycle after the FIFO empties; inst_count frozen.
- MAX_CYCLES=50, no HALT -> timeout=1 and cycle_count=50 with done=1 once drained. Assert rst while in DONE -> all outputs back to 0, state RUN.

Source files
------------

// File: rtl/commit_trace_unit.sv
// commit_trace_unit
//   Retire-trace recorder for the pipelined WISC CPU. Each WB-stage retire
//   event is classified (REG / STORE / HALT / OTHER) and numbered. It is then
//   filtered by mode and buffered in a FIFO that is drained through a
//   valid/ready port. The block also keeps cycle, instruction and drop
//   counters, performs the halt-drain sequence and runs a cycle watchdog.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   mode[2:0]         keep mask: bit0 REG, bit1 STORE, bit2 OTHER (HALT always kept)
//   ret_*             retire event from WB (valid, pc, inst, regwrite, wreg,
//                     wdata, memread, memwrite, addr, mdata, halt)
//   out_valid/ready   FIFO head handshake
//   out_kind/load/inum/pc/reg/val/addr   head entry fields (0 while !out_valid)
//   cycle_count       cycles counted in RUN and HALT_PEND
//   inst_count        accepted retire events
//   drop_count        entries lost to overflow
//   overflow, timeout sticky status flags
//   done              stopped and FIFO drained
module commit_trace_unit #(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        mode,
  input  logic              ret_valid,
  input  logic [DATA_W-1:0] ret_pc,
  input  logic [DATA_W-1:0] ret_inst,
  input  logic              ret_regwrite,
  input  logic [3:0]        ret_wreg,
  input  logic [DATA_W-1:0] ret_wdata,
  input  logic              ret_memread,
  input  logic              ret_memwrite,
  input  logic [DATA_W-1:0] ret_addr,
  input  logic [DATA_W-1:0] ret_mdata,
  input  logic              ret_halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_kind,
  output logic              out_load,
  output logic [CNT_W-1:0]  out_inum,
  output logic [DATA_W-1:0] out_pc,
  output logic [3:0]        out_reg,
  output logic [DATA_W-1:0] out_val,
  output logic [DATA_W-1:0] out_addr,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  inst_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic              overflow,
  output logic              timeout,
  output logic              done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MAX_CYCLES - 1);
  localparam bit               WD_EN    = (MAX_CYCLES != 0);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_PEND = 2'd1,
    DRAIN     = 2'd2,
    DONE      = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    K_OTHER = 2'd0,
    K_REG   = 2'd1,
    K_STORE = 2'd2,
    K_HALT  = 2'd3
  } kind_t;

  typedef struct packed {
    logic [1:0]        kind;
    logic              load;
    logic [CNT_W-1:0]  inum;
    logic [DATA_W-1:0] pc;
    logic [3:0]        rg;
    logic [DATA_W-1:0] val;
    logic [DATA_W-1:0] addr;
  } entry_t;

  state_t          state, stateNext;
  entry_t          mem [DEPTH];
  entry_t          pendEntry;
  entry_t          evEntry;
  entry_t          pushEntry;
  entry_t          headEntry;
  logic [AW-1:0]   wrPtr, rdPtr;
  logic [CW-1:0]   count;

  logic            evKeep;
  logic            accept;
  logic            fifoFull, fifoEmpty;
  logic            pop, push, space;
  logic            drop, pendLoad;
  logic            wdFire;
  logic            cycInc;

  // The instruction word is carried for future trace formats; it does not
  // affect classification.
  logic            instUnused;
  assign instUnused = ^ret_inst;

  // Event classification; regwrite wins over halt, halt over memwrite.
  always_comb begin
    evEntry      = '0;
    evEntry.inum = inst_count;
    evEntry.pc   = ret_pc;
    if (ret_regwrite) begin
      evEntry.kind = K_REG;
      evEntry.load = ret_memread;
      evEntry.rg   = ret_wreg;
      evEntry.val  = ret_wdata;
      evEntry.addr = ret_memread ? ret_addr : '0;
    end else if (ret_halt) begin
      evEntry.kind = K_HALT;
    end else if (ret_memwrite) begin
      evEntry.kind = K_STORE;
      evEntry.val  = ret_mdata;
      evEntry.addr = ret_addr;
    end else begin
      evEntry.kind = K_OTHER;
    end
  end

  always_comb begin
    unique case (evEntry.kind)
      K_REG:   evKeep = mode[0];
      K_STORE: evKeep = mode[1];
      K_OTHER: evKeep = mode[2];
      default: evKeep = 1'b1;
    endcase
  end

  assign fifoFull  = (count == FULL_CNT);
  assign fifoEmpty = (count == '0);
  assign out_valid = !fifoEmpty;
  assign pop       = out_valid && out_ready;
  // A pop on the same edge frees a slot, so a full FIFO can still take a push.
  assign space     = !fifoFull || pop;
  assign accept    = (state == RUN) && ret_valid;
  assign wdFire    = WD_EN && (state == RUN) && (cycle_count == WD_LIMIT);
  assign cycInc    = (state == RUN) || (state == HALT_PEND);

  // Next-state and push/drop decisions.
  always_comb begin
    stateNext = state;
    push      = 1'b0;
    pushEntry = evEntry;
    drop      = 1'b0;
    pendLoad  = 1'b0;
    unique case (state)
      RUN: begin
        if (accept && evKeep) begin
          if (evEntry.kind == K_HALT) begin
            if (space) begin
              push      = 1'b1;
              stateNext = DRAIN;
            end else begin
              pendLoad  = 1'b1;
              stateNext = HALT_PEND;
            end
          end else if (space) begin
            push = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
        // A HALT arriving on the watchdog edge keeps its own path (it may
        // need the pending register); otherwise the watchdog forces DRAIN.
        if (wdFire && (stateNext == RUN)) begin
          stateNext = DRAIN;
        end
      end
      HALT_PEND: begin
        if (space) begin
          push      = 1'b1;
          pushEntry = pendEntry;
          stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if (fifoEmpty) begin
          stateNext = DONE;
        end
      end
      default: begin
        stateNext = DONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      pendEntry   <= '0;
      cycle_count <= '0;
      inst_count  <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
      timeout     <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state <= stateNext;

      if (push) begin
        mem[wrPtr] <= pushEntry;
        wrPtr      <= wrPtr + AW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (pendLoad) begin
        pendEntry <= evEntry;
      end

      if (cycInc && (cycle_count != '1)) begin
        cycle_count <= cycle_count + CNT_W'(1);
      end
      if (accept && (inst_count != '1)) begin
        inst_count <= inst_count + CNT_W'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) begin
          drop_count <= drop_count + CNT_W'(1);
        end
      end
      if (wdFire) begin
        timeout <= 1'b1;
      end
    end
  end

  assign headEntry = out_valid ? mem[rdPtr] : '0;
  assign out_kind  = headEntry.kind;
  assign out_load  = headEntry.load;
  assign out_inum  = headEntry.inum;
  assign out_pc    = headEntry.pc;
  assign out_reg   = headEntry.rg;
  assign out_val   = headEntry.val;
  assign out_addr  = headEntry.addr;
  assign done      = (state == DONE);

endmodule

// File: tb/tb_commit_trace_unit.sv
// tb_commit_trace_unit
//   Directed bench for commit_trace_unit (DEPTH=4, MAX_CYCLES=50). Each
//   section starts from reset; expected values are hand-computed constants.
module tb_commit_trace_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mode;
  logic        ret_valid;
  logic [15:0] ret_pc;
  logic [15:0] ret_inst;
  logic        ret_regwrite;
  logic [3:0]  ret_wreg;
  logic [15:0] ret_wdata;
  logic        ret_memread;
  logic        ret_memwrite;
  logic [15:0] ret_addr;
  logic [15:0] ret_mdata;
  logic        ret_halt;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_kind;
  logic        out_load;
  logic [31:0] out_inum;
  logic [15:0] out_pc;
  logic [3:0]  out_reg;
  logic [15:0] out_val;
  logic [15:0] out_addr;
  logic [31:0] cycle_count;
  logic [31:0] inst_count;
  logic [31:0] drop_count;
  logic        overflow;
  logic        timeout;
  logic        done;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  commit_trace_unit #(
    .DATA_W    (16),
    .DEPTH     (4),
    .CNT_W     (32),
    .MAX_CYCLES(50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .ret_valid   (ret_valid),
    .ret_pc      (ret_pc),
    .ret_inst    (ret_inst),
    .ret_regwrite(ret_regwrite),
    .ret_wreg    (ret_wreg),
    .ret_wdata   (ret_wdata),
    .ret_memread (ret_memread),
    .ret_memwrite(ret_memwrite),
    .ret_addr    (ret_addr),
    .ret_mdata   (ret_mdata),
    .ret_halt    (ret_halt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_kind    (out_kind),
    .out_load    (out_load),
    .out_inum    (out_inum),
    .out_pc      (out_pc),
    .out_reg     (out_reg),
    .out_val     (out_val),
    .out_addr    (out_addr),
    .cycle_count (cycle_count),
    .inst_count  (inst_count),
    .drop_count  (drop_count),
    .overflow    (overflow),
    .timeout     (timeout),
    .done        (done)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic retIdle();
    ret_valid    = 1'b0;
    ret_pc       = '0;
    ret_inst     = '0;
    ret_regwrite = 1'b0;
    ret_wreg     = '0;
    ret_wdata    = '0;
    ret_memread  = 1'b0;
    ret_memwrite = 1'b0;
    ret_addr     = '0;
    ret_mdata    = '0;
    ret_halt     = 1'b0;
  endtask

  task automatic retReg(input logic [15:0] pc, input logic [3:0] wreg, input logic [15:0] wdata,
                        input logic load, input logic [15:0] addr);
    retIdle();
    ret_valid    = 1'b1;
    ret_pc       = pc;
    ret_inst     = 16'h1000 | pc;
    ret_regwrite = 1'b1;
    ret_wreg     = wreg;
    ret_wdata    = wdata;
    ret_memread  = load;
    ret_addr     = addr;
  endtask

  task automatic retStore(input logic [15:0] pc, input logic [15:0] addr, input logic [15:0] mdata);
    retIdle();
    ret_valid    = 1'b1;
    ret_pc       = pc;
    ret_inst     = 16'h9000 | pc;
    ret_memwrite = 1'b1;
    ret_addr     = addr;
    ret_mdata    = mdata;
  endtask

  task automatic retOther(input logic [15:0] pc);
    retIdle();
    ret_valid = 1'b1;
    ret_pc    = pc;
    ret_inst  = 16'hC000 | pc;
  endtask

  task automatic retHalt(input logic [15:0] pc);
    retIdle();
    ret_valid = 1'b1;
    ret_pc    = pc;
    ret_inst  = 16'h0000;
    ret_halt  = 1'b1;
  endtask

  task automatic doReset();
    rst       = 1'b1;
    retIdle();
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic checkCleared(input string tag);
    checkVal({tag, ".valid"},  32'(out_valid),   32'd0);
    checkVal({tag, ".kind"},   32'(out_kind),    32'd0);
    checkVal({tag, ".inum"},   out_inum,         32'd0);
    checkVal({tag, ".pc"},     32'(out_pc),      32'd0);
    checkVal({tag, ".val"},    32'(out_val),     32'd0);
    checkVal({tag, ".cycles"}, cycle_count,      32'd0);
    checkVal({tag, ".insts"},  inst_count,       32'd0);
    checkVal({tag, ".drops"},  drop_count,       32'd0);
    checkVal({tag, ".ovf"},    32'(overflow),    32'd0);
    checkVal({tag, ".tmo"},    32'(timeout),     32'd0);
    checkVal({tag, ".done"},   32'(done),        32'd0);
  endtask

  initial begin
    mode = 3'd7;
    doReset();
    checkCleared("reset");

    // Basic REG / load / STORE sequence with a free-running consumer.
    mode      = 3'd7;
    out_ready = 1'b1;
    retReg(16'h0000, 4'd3, 16'h0005, 1'b0, 16'h0000);
    step();
    checkVal("add.valid", 32'(out_valid), 32'd1);
    checkVal("add.kind",  32'(out_kind),  32'd1);
    checkVal("add.inum",  out_inum,       32'd0);
    checkVal("add.reg",   32'(out_reg),   32'd3);
    checkVal("add.val",   32'(out_val),   32'h0005);
    checkVal("add.addr",  32'(out_addr),  32'h0000);
    retReg(16'h0002, 4'd4, 16'h1234, 1'b1, 16'h0010);
    step();
    checkVal("ld.kind", 32'(out_kind), 32'd1);
    checkVal("ld.load", 32'(out_load), 32'd1);
    checkVal("ld.addr", 32'(out_addr), 32'h0010);
    checkVal("ld.val",  32'(out_val),  32'h1234);
    checkVal("ld.inum", out_inum,      32'd1);
    retStore(16'h0004, 16'h0020, 16'hBEEF);
    step();
    checkVal("st.kind", 32'(out_kind), 32'd2);
    checkVal("st.val",  32'(out_val),  32'hBEEF);
    checkVal("st.addr", 32'(out_addr), 32'h0020);
    checkVal("st.reg",  32'(out_reg),  32'd0);
    checkVal("st.inum", out_inum,      32'd2);
    checkVal("st.pc",   32'(out_pc),   32'h0004);
    retIdle();
    step();
    checkVal("seq.empty", 32'(out_valid), 32'd0);
    checkVal("seq.insts", inst_count,     32'd3);

    // Mode filter: only REG entries kept, numbering still counts all.
    doReset();
    mode      = 3'd1;
    out_ready = 1'b1;
    retOther(16'h0010);
    step();
    checkVal("flt.br", 32'(out_valid), 32'd0);
    retStore(16'h0012, 16'h0030, 16'h5555);
    step();
    checkVal("flt.st", 32'(out_valid), 32'd0);
    retReg(16'h0014, 4'd5, 16'h0007, 1'b0, 16'h0000);
    step();
    checkVal("flt.valid", 32'(out_valid), 32'd1);
    checkVal("flt.kind",  32'(out_kind),  32'd1);
    checkVal("flt.inum",  out_inum,       32'd2);
    checkVal("flt.insts", inst_count,     32'd3);
    retIdle();
    step();

    // Overflow: 6 REG retires into a 4-deep FIFO with no consumer.
    doReset();
    mode      = 3'd7;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      retReg(16'(2 * i), 4'd1, 16'(i), 1'b0, 16'h0000);
      step();
    end
    retIdle();
    checkVal("ovf.drops", drop_count,     32'd2);
    checkVal("ovf.flag",  32'(overflow),  32'd1);
    checkVal("ovf.insts", inst_count,     32'd6);
    checkVal("ovf.hold",  out_inum,       32'd0);
    step();
    checkVal("ovf.stable", out_inum,      32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkVal($sformatf("ovf.v%0d", i), 32'(out_valid), 32'd1);
      checkVal($sformatf("ovf.n%0d", i), out_inum,       32'(i));
      step();
    end
    checkVal("ovf.empty", 32'(out_valid), 32'd0);

    // HALT arriving with a full FIFO goes pending; later retires ignored.
    doReset();
    mode      = 3'd7;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      retReg(16'(2 * i), 4'd2, 16'(16'h0100 + i), 1'b0, 16'h0000);
      step();
    end
    retHalt(16'h0040);
    step();
    checkVal("hp.insts", inst_count, 32'd5);
    retReg(16'h0042, 4'd6, 16'h0AAA, 1'b0, 16'h0000);
    step();
    retReg(16'h0044, 4'd7, 16'h0BBB, 1'b0, 16'h0000);
    step();
    retIdle();
    checkVal("hp.insts2", inst_count,  32'd5);
    checkVal("hp.drops",  drop_count,  32'd0);
    checkVal("hp.done",   32'(done),   32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkVal($sformatf("hp.v%0d", i), 32'(out_valid), 32'd1);
      checkVal($sformatf("hp.n%0d", i), out_inum,       32'(i));
      checkVal($sformatf("hp.k%0d", i), 32'(out_kind),  (i == 4) ? 32'd3 : 32'd1);
      if (i == 4) begin
        checkVal("hp.pc",  32'(out_pc),  32'h0040);
        checkVal("hp.val", 32'(out_val), 32'd0);
      end
      step();
    end
    checkVal("hp.empty",  32'(out_valid), 32'd0);
    checkVal("hp.nodone", 32'(done),      32'd0);
    step();
    checkVal("hp.done1",  32'(done),      32'd1);
    checkVal("hp.insts3", inst_count,     32'd5);
    checkVal("hp.cycles", cycle_count,    32'd8);

    // Watchdog with no HALT, then reset out of DONE.
    doReset();
    mode      = 3'd7;
    out_ready = 1'b1;
    repeat (49) step();
    checkVal("wd.c49",  cycle_count,   32'd49);
    checkVal("wd.tmo0", 32'(timeout),  32'd0);
    step();
    checkVal("wd.tmo1", 32'(timeout),  32'd1);
    checkVal("wd.c50",  cycle_count,   32'd50);
    checkVal("wd.drn",  32'(done),     32'd0);
    step();
    checkVal("wd.done", 32'(done),     32'd1);
    repeat (3) step();
    checkVal("wd.frz",  cycle_count,   32'd50);
    retReg(16'h0060, 4'd1, 16'h0001, 1'b0, 16'h0000);
    step();
    checkVal("wd.ign",  32'(out_valid), 32'd0);
    checkVal("wd.ins",  inst_count,     32'd0);
    rst = 1'b1;
    retIdle();
    out_ready = 1'b0;
    step();
    checkCleared("rst2");
    rst = 1'b0;
    retReg(16'h0070, 4'd9, 16'h0042, 1'b0, 16'h0000);
    step();
    retIdle();
    checkVal("rst2.run",  32'(out_valid), 32'd1);
    checkVal("rst2.inum", out_inum,       32'd0);
    checkVal("rst2.val",  32'(out_val),   32'h0042);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
